// File: rtl/pipe_skid_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg_pkg
// Description : Shared types and constants for the pipeline skid register:
//               occupancy state encoding, default exception-code width and
//               the exception-code values carried on the sideband.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_skid_reg_pkg;

    // Default width of the exception-code sideband
    localparam int EXC_W_DEFAULT = 5;

    // Occupancy of the register: nothing, main entry only, main + skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Exception-code values carried through unmodified with each beat
    localparam logic [EXC_W_DEFAULT-1:0] EXC_INT  = 5'd0;   // interrupt
    localparam logic [EXC_W_DEFAULT-1:0] EXC_MOD  = 5'd1;   // TLB modification
    localparam logic [EXC_W_DEFAULT-1:0] EXC_TLBL = 5'd2;   // TLB miss, load/fetch
    localparam logic [EXC_W_DEFAULT-1:0] EXC_TLBS = 5'd3;   // TLB miss, store
    localparam logic [EXC_W_DEFAULT-1:0] EXC_ADEL = 5'd4;   // address error, load/fetch
    localparam logic [EXC_W_DEFAULT-1:0] EXC_ADES = 5'd5;   // address error, store
    localparam logic [EXC_W_DEFAULT-1:0] EXC_IBE  = 5'd6;   // bus error, fetch
    localparam logic [EXC_W_DEFAULT-1:0] EXC_DBE  = 5'd7;   // bus error, data
    localparam logic [EXC_W_DEFAULT-1:0] EXC_SYS  = 5'd8;   // syscall
    localparam logic [EXC_W_DEFAULT-1:0] EXC_BP   = 5'd9;   // breakpoint
    localparam logic [EXC_W_DEFAULT-1:0] EXC_RI   = 5'd10;  // reserved instruction
    localparam logic [EXC_W_DEFAULT-1:0] EXC_CPU  = 5'd11;  // coprocessor unusable
    localparam logic [EXC_W_DEFAULT-1:0] EXC_OV   = 5'd12;  // arithmetic overflow
    localparam logic [EXC_W_DEFAULT-1:0] EXC_TR   = 5'd13;  // trap

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that advances by one when inc is high and sticks
//               at its all-ones maximum instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,     // asynchronous, active-low
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count up on inc, holding once the maximum value is reached
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Two-entry pipeline register with fully registered handshake.
//               A main entry drives the downstream beat; a skid entry absorbs
//               the one beat that can arrive after the downstream stalls.
//               Carries an exception code and a delay-slot flag with each
//               beat and counts back-pressure cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int EXC_W  = EXC_W_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,      // asynchronous, active-low
    input  logic              flush,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [EXC_W-1:0]  in_exc,
    input  logic              in_bd,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [EXC_W-1:0]  out_exc,
    output logic              out_bd,

    output logic [CNT_W-1:0]  stall_cnt
);

    // One entry is {data, exc, bd} packed into a single vector
    localparam int ENT_W = DATA_W + EXC_W + 1;

    state_t            state;
    state_t            state_nxt;
    logic [ENT_W-1:0]  main_q;
    logic [ENT_W-1:0]  main_nxt;
    logic [ENT_W-1:0]  skid_q;
    logic [ENT_W-1:0]  skid_nxt;
    logic [ENT_W-1:0]  in_ent;
    logic              accept;
    logic              take;

    // Handshake flags come straight from the state register, so neither
    // depends combinationally on in_valid or out_ready
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);

    // Vacated entries are zeroed, so the main entry reads 0 whenever empty
    assign {out_data, out_exc, out_bd} = main_q;

    assign in_ent = {in_data, in_exc, in_bd};
    assign accept = in_valid && in_ready;
    assign take   = out_valid && out_ready;

    // Next-state and entry updates; flush overrides every other event
    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;

        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_nxt  = in_ent;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && take) begin
                        main_nxt  = in_ent;
                    end else if (accept) begin
                        skid_nxt  = in_ent;
                        state_nxt = TWO;
                    end else if (take) begin
                        main_nxt  = '0;
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a take can change things
                    if (take) begin
                        main_nxt  = skid_q;
                        skid_nxt  = '0;
                        state_nxt = ONE;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    main_nxt  = '0;
                    skid_nxt  = '0;
                end
            endcase
        end
    end

    // State and entry registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_nxt;
            skid_q <= skid_nxt;
        end
    end

    // Back-pressure counter: a beat is waiting but downstream is not ready
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid && !out_ready),
        .count (stall_cnt)
    );

endmodule
`default_nettype wire
